// File: rtl/rtc_bus_pkg.sv
// -----------------------------------------------------------------------------
// rtc_bus_pkg
// Shared definitions for the RTC bus responder: bus width, default register
// count, FSM state encoding and a small strobe edge helper.
// -----------------------------------------------------------------------------
package rtc_bus_pkg;

    localparam int RTC_DW    = 8;
    localparam int RTC_NREGS = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_ARMED = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } rtc_state_e;

    // Rising edge of an active-low strobe, i.e. the strobe being released.
    function automatic logic rise_edge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/rtc_regfile.sv
// -----------------------------------------------------------------------------
// rtc_regfile
// NREGS x DW register file with two synchronous write ports and one
// asynchronous read port. Port 0 (bus) wins over port 1 (local update) when
// both target the same entry in the same cycle.
//
// Ports:
//   clk_i, reset_ni        clock, synchronous active-low reset (clears all)
//   we0_i/waddr0_i/wdata0_i  write port 0 (priority)
//   we1_i/waddr1_i/wdata1_i  write port 1
//   raddr_i / rdata_o        asynchronous read; out-of-range reads return 0
// -----------------------------------------------------------------------------
module rtc_regfile #(
    parameter int NREGS = 16,
    parameter int DW    = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          we0_i,
    input  logic [AW-1:0] waddr0_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] waddr1_i,
    input  logic [DW-1:0] wdata1_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] regs_q [NREGS];

    // Storage update: reset clears, port 0 overrides port 1 per entry.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!reset_ni) begin
                regs_q[i] <= {DW{1'b0}};
            end else if (we0_i && (waddr0_i == AW'(i))) begin
                regs_q[i] <= wdata0_i;
            end else if (we1_i && (waddr1_i == AW'(i))) begin
                regs_q[i] <= wdata1_i;
            end else begin
                regs_q[i] <= regs_q[i];
            end
        end
    end

    // Asynchronous read with range guard for non power-of-two depths.
    always_comb begin
        rdata_o = {DW{1'b0}};
        if (int'(raddr_i) < NREGS) begin
            rdata_o = regs_q[raddr_i];
        end else begin
            rdata_o = {DW{1'b0}};
        end
    end

endmodule

// File: rtl/rtc_bus_responder.sv
// -----------------------------------------------------------------------------
// rtc_bus_responder
// Responder side of the multiplexed RTC bus. Decodes address/data phases on
// the registered strobes, holds a register file, drives read data back onto
// the AD bus and merges local timekeeping updates.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   a_d, cs, wr, rd       bus controls (a_d low = address; strobes active-low)
//   bus_in                AD bus value from the initiator
//   bus_out, bus_oe       read data and its output enable
//   upd_en/upd_addr/upd_data  one-cycle local register update
//   addr_err              pulse with xfer_done when the address is out of range
//   xfer_done             pulse when a data phase completes
// -----------------------------------------------------------------------------
module rtc_bus_responder
    import rtc_bus_pkg::*;
#(
    parameter int NREGS = RTC_NREGS,
    parameter int DW    = RTC_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_d,
    input  logic          cs,
    input  logic          wr,
    input  logic          rd,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] bus_out,
    output logic          bus_oe,
    input  logic          upd_en,
    input  logic [3:0]    upd_addr,
    input  logic [DW-1:0] upd_data,
    output logic          addr_err,
    output logic          xfer_done
);

    localparam int AW = $clog2(NREGS);

    // Registered bus inputs and the previous strobe values for edge detect.
    logic          a_d_q, cs_q, wr_q, rd_q;
    logic [DW-1:0] bus_in_q;
    logic          cs_prev_q, wr_prev_q, rd_prev_q;

    rtc_state_e    state_q;
    logic          sync_q;       // bus seen idle (cs high) since reset
    logic [DW-1:0] addr_cap_q;   // address being collected in ADDR
    logic [DW-1:0] addr_reg_q;   // committed address, used by data phases
    logic [DW-1:0] data_q;       // write data collected in WRITE
    logic [DW-1:0] bus_out_q;
    logic          bus_oe_q, addr_err_q, xfer_done_q;

    logic          cs_rise_s, wr_rise_s, rd_rise_s;
    logic          addr_bad_s;
    logic          bus_wen_s, upd_wen_s;
    logic [DW-1:0] rd_data_s;

    // Input capture. Strobes reset to their inactive level so a transfer that
    // straddles reset cannot produce a spurious edge afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_d_q     <= 1'b0;
            cs_q      <= 1'b1;
            wr_q      <= 1'b1;
            rd_q      <= 1'b1;
            bus_in_q  <= {DW{1'b0}};
            cs_prev_q <= 1'b1;
            wr_prev_q <= 1'b1;
            rd_prev_q <= 1'b1;
        end else begin
            a_d_q     <= a_d;
            cs_q      <= cs;
            wr_q      <= wr;
            rd_q      <= rd;
            bus_in_q  <= bus_in;
            cs_prev_q <= cs_q;
            wr_prev_q <= wr_q;
            rd_prev_q <= rd_q;
        end
    end

    // Strobe edges, address range check and register-file write enables.
    always_comb begin
        cs_rise_s  = rise_edge(cs_q, cs_prev_q);
        wr_rise_s  = rise_edge(wr_q, wr_prev_q);
        rd_rise_s  = rise_edge(rd_q, rd_prev_q);
        // Any bit above the index range, or an index past NREGS, is an error.
        addr_bad_s = (addr_reg_q >= DW'(NREGS));
        bus_wen_s  = (state_q == ST_WRITE) && wr_rise_s && !addr_bad_s;
        upd_wen_s  = upd_en && (int'(upd_addr) < NREGS);
    end

    // Bus-side protocol FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sync_q      <= 1'b0;
            addr_cap_q  <= {DW{1'b0}};
            addr_reg_q  <= {DW{1'b0}};
            data_q      <= {DW{1'b0}};
            bus_out_q   <= {DW{1'b0}};
            bus_oe_q    <= 1'b0;
            addr_err_q  <= 1'b0;
            xfer_done_q <= 1'b0;
        end else begin
            xfer_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
            // A transfer cut by reset is ignored until cs has been released.
            if (cs_q) begin
                sync_q <= 1'b1;
            end else begin
                sync_q <= sync_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (sync_q && !cs_q && !wr_q && !a_d_q) begin
                        state_q    <= ST_ADDR;
                        addr_cap_q <= bus_in_q;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end

                ST_ADDR: begin
                    if (wr_rise_s) begin
                        // Address only becomes current once the phase completes,
                        // so an aborted phase leaves the old address intact.
                        state_q    <= ST_ARMED;
                        addr_reg_q <= addr_cap_q;
                    end else if (cs_rise_s) begin
                        state_q    <= ST_IDLE;
                    end else begin
                        state_q    <= ST_ADDR;
                        if (!cs_q && !wr_q && !a_d_q) begin
                            addr_cap_q <= bus_in_q;
                        end else begin
                            addr_cap_q <= addr_cap_q;
                        end
                    end
                end

                ST_ARMED: begin
                    if (!cs_q && !wr_q && !a_d_q) begin
                        state_q    <= ST_ADDR;
                        addr_cap_q <= bus_in_q;
                    end else if (!cs_q && !wr_q && a_d_q) begin
                        // Write checked first: rd and wr both low is a write.
                        state_q    <= ST_WRITE;
                        data_q     <= bus_in_q;
                    end else if (!cs_q && !rd_q && a_d_q) begin
                        state_q    <= ST_READ;
                        bus_oe_q   <= 1'b1;
                        bus_out_q  <= addr_bad_s ? {DW{1'b0}} : rd_data_s;
                    end else begin
                        state_q    <= ST_ARMED;
                    end
                end

                ST_WRITE: begin
                    if (wr_rise_s) begin
                        state_q     <= ST_IDLE;
                        xfer_done_q <= 1'b1;
                        addr_err_q  <= addr_bad_s;
                    end else if (cs_rise_s) begin
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q     <= ST_WRITE;
                        if (!wr_q) begin
                            data_q <= bus_in_q;
                        end else begin
                            data_q <= data_q;
                        end
                    end
                end

                ST_READ: begin
                    if (rd_rise_s || cs_rise_s) begin
                        state_q     <= ST_IDLE;
                        bus_oe_q    <= 1'b0;
                        bus_out_q   <= {DW{1'b0}};
                        xfer_done_q <= 1'b1;
                        addr_err_q  <= addr_bad_s;
                    end else begin
                        // Data sampled on entry is held for the whole phase.
                        state_q     <= ST_READ;
                    end
                end

                default: begin
                    state_q  <= ST_IDLE;
                    bus_oe_q <= 1'b0;
                end
            endcase
        end
    end

    rtc_regfile #(
        .NREGS (NREGS),
        .DW    (DW),
        .AW    (AW)
    ) u_regfile (
        .clk_i    (clk),
        .reset_ni (reset),
        .we0_i    (bus_wen_s),
        .waddr0_i (addr_reg_q[AW-1:0]),
        .wdata0_i (data_q),
        .we1_i    (upd_wen_s),
        .waddr1_i (upd_addr[AW-1:0]),
        .wdata1_i (upd_data),
        .raddr_i  (addr_reg_q[AW-1:0]),
        .rdata_o  (rd_data_s)
    );

    assign bus_out   = bus_out_q;
    assign bus_oe    = bus_oe_q;
    assign addr_err  = addr_err_q;
    assign xfer_done = xfer_done_q;

endmodule
